regfile_test_loader: RTL and testbench
======================================

Name: regfile_test_loader

Overview:
- Test-port writer for the processor register file: preloads registers before a run by driving the skeleton's test port (test, t_ctrl_writeEnable, t_ctrl_writeReg, t_data_writeReg).
- Accepts a stream of (register, value) entries over a valid/ready handshake and writes each one while holding test high.
- Optionally reads each write back through port A and flags mismatches.
- Sits between a bench or boot sequencer and the skeleton test port; it is the writing counterpart of the register-check reader.

Parameters:
- VERIFY, 1, 1 = read back and compare each written register; 0 = write only.
- READ_LAT, 1, cycles readRegA is held before t_data_readRegA is sampled (legal range 1..7).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low, sampled on posedge clock.
- ld_valid  in  1  entry present.
- ld_ready  out  1  loader can accept an entry.
- ld_reg  in  5  target register number.
- ld_data  in  32  value to write.
- ld_last  in  1  marks the final entry of a session.
- test  out  1  selects test-port inputs into the regfile.
- t_ctrl_writeEnable  out  1  regfile write enable.
- t_ctrl_writeReg  out  5  regfile write address.
- t_data_writeReg  out  32  regfile write data.
- t_ctrl_readRegA  out  5  read-back address.
- t_ctrl_readRegB  out  5  constant 0.
- t_data_readRegA  in  32  read-back data.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse at session end.
- mismatch  out  1  sticky: a read-back differed from the value written.
- mismatch_reg  out  5  register of the first mismatch.
- err_r0  out  1  sticky: an entry targeted r0.
- write_count  out  6  writes performed this session; saturates at 63.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE.
  - All outputs and internal registers go to 0, except ld_ready=1.
  - Registers already written are not undone.
  - Reset mid-session aborts immediately; no done pulse is produced.
- States: IDLE, ACCEPT, WRITE, READ, DONE.
- IDLE:
  - test=0, busy=0, ld_ready=1.
  - On ld_valid&ld_ready: latch reg, data and last; clear mismatch, mismatch_reg, err_r0 and write_count; go to WRITE.
- ACCEPT:
  - test=1, busy=1, ld_ready=1.
  - On handshake: latch the entry and go to WRITE; sticky flags are not cleared.
  - With no valid, stay in ACCEPT indefinitely; test remains 1.
- WRITE (exactly 1 cycle):
  - test=1, writeEnable=1, writeReg and data driven from the latched entry; write_count+1.
  - r0 entry: writeEnable=0, err_r0 set, no count increment, and READ is skipped.
  - Next state: READ if VERIFY=1 and the register is non-zero. Otherwise DONE if the entry was last, else ACCEPT.
- READ (READ_LAT cycles):
  - writeEnable=0; t_ctrl_readRegA = latched register.
  - At the posedge ending the last READ cycle, compare t_data_readRegA with the latched data.
  - On inequality: set mismatch. Load mismatch_reg only if mismatch was previously clear (first-mismatch capture).
  - Next state: DONE if the entry was last, else ACCEPT.
- DONE (1 cycle):
  - done=1, test=1, busy=1, ld_ready=0.
  - Next state IDLE, where test drops to 0.
  - Sticky flags and write_count hold until the next session's first accept.
- ld_ready is 0 in WRITE, READ and DONE. An entry presented during those states waits (ld_valid must hold) and transfers on the first cycle ld_ready=1.
- Latency:
  - Accept to write edge: 1 cycle.
  - Per-entry throughput: 2 cycles (VERIFY=0) or 2+READ_LAT cycles (VERIFY=1), counting the ACCEPT handshake cycle.
- ld_last on a single-entry session: accept, then WRITE, READ (if VERIFY), DONE.
- write_count stops at 63; further writes still occur.
- t_ctrl_readRegA is 0 outside READ; t_ctrl_readRegB is always 0.

Test Plan:
1. Single entry with VERIFY=1, READ_LAT=1: send (r1, 65535, last).
   - Write occurs 1 cycle after accept; readback equals 65535.
   - done pulses once; mismatch=0; write_count=1; test returns to 0 the cycle after done.
2. Burst of 31 entries r1..r31 with value 0x1000+n, last on r31, ld_valid held continuously.
   - ld_ready toggles per the throughput rule; write_count=31; done pulses once; every register reads back correctly.
3. Entries (r0, 5), (r2, 7, last).
   - r0 is never written (writeEnable stays 0 in that WRITE); err_r0=1; write_count=1; r2 equals 7.
4. Regfile model forces r4 readback to 0xDEAD: send r3, r4, r5.
   - mismatch=1, mismatch_reg=4.
   - Corrupt r5 readback as well: mismatch_reg stays 4.
5. Assert reset low during READ of the second entry of three.
   - Next cycle: all outputs 0, ld_ready=1, no done pulse; the first register retains its written value.
6. Stall: ld_valid dropped for 10 cycles mid-session.
   - State stays ACCEPT with test=1 and writeEnable=0 throughout; the session completes normally when valid returns.

Source files
------------

// File: rtl/regfile_test_loader.sv
// regfile_test_loader
//   Preloads the processor register file through the skeleton's test port.
//   (register, value) entries arrive on a valid/ready stream. Each entry is
//   written while test is held high. When VERIFY is set, the entry is then
//   read back through port A and compared against the value written.
//
// Parameters
//   VERIFY    1: read back and compare every non-r0 write, 0: write only
//   READ_LAT  cycles readRegA is held before t_data_readRegA is sampled (1..7)
//
// Ports
//   clock, reset        system clock; synchronous active-low reset
//   ld_valid/ld_ready   entry handshake; ld_reg, ld_data, ld_last carry the entry
//   test                selects the test-port inputs into the regfile
//   t_ctrl_writeEnable, t_ctrl_writeReg, t_data_writeReg   regfile write port
//   t_ctrl_readRegA, t_data_readRegA                       read-back port
//   t_ctrl_readRegB     tied to 0
//   busy, done          session in progress / one-cycle end-of-session pulse
//   mismatch, mismatch_reg   sticky read-back error and first failing register
//   err_r0              sticky: an entry targeted r0
//   write_count         writes performed this session, saturating at 63
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no session; test low; first handshake clears the flags
// S_ACCEPT | session open; test held high, waiting for the next entry
// S_WRITE  | one-cycle write of the latched entry (suppressed for r0)
// S_READ   | READ_LAT cycles addressing the entry on port A, then compare
// S_DONE   | one-cycle done pulse; test drops on return to idle
module regfile_test_loader #(
  parameter bit          VERIFY   = 1'b1,
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_reg,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        test,
  output logic        t_ctrl_writeEnable,
  output logic [4:0]  t_ctrl_writeReg,
  output logic [31:0] t_data_writeReg,
  output logic [4:0]  t_ctrl_readRegA,
  output logic [4:0]  t_ctrl_readRegB,
  input  logic [31:0] t_data_readRegA,
  output logic        busy,
  output logic        done,
  output logic        mismatch,
  output logic [4:0]  mismatch_reg,
  output logic        err_r0,
  output logic [5:0]  write_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  reg_q;
  logic [31:0] data_q;
  logic        last_q;
  logic [2:0]  lat_cnt;
  logic        accept;
  logic        read_tc;
  logic        reg_nz;

  // ld_ready depends on state alone, so the handshake never loops back
  // through the next-state logic.
  assign ld_ready        = (state == S_IDLE) || (state == S_ACCEPT);
  assign accept          = ld_valid && ld_ready;
  assign reg_nz          = (reg_q != 5'd0);
  assign read_tc         = (state == S_READ) && (lat_cnt == 3'd0);
  assign t_ctrl_readRegB = 5'd0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      reg_q        <= 5'd0;
      data_q       <= 32'd0;
      last_q       <= 1'b0;
      lat_cnt      <= 3'd0;
      mismatch     <= 1'b0;
      mismatch_reg <= 5'd0;
      err_r0       <= 1'b0;
      write_count  <= 6'd0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        reg_q  <= ld_reg;
        data_q <= ld_data;
        last_q <= ld_last;
      end

      // Flags from the previous session stay visible until a new one starts.
      if (accept && (state == S_IDLE)) begin
        mismatch     <= 1'b0;
        mismatch_reg <= 5'd0;
        err_r0       <= 1'b0;
        write_count  <= 6'd0;
      end

      if (state == S_WRITE) begin
        if (!reg_nz) begin
          err_r0 <= 1'b1;
        end else if (write_count != 6'd63) begin
          write_count <= write_count + 6'd1;
        end
        // Down-counter: the compare happens on the edge where it reads 0.
        lat_cnt <= 3'(READ_LAT - 1);
      end else if ((state == S_READ) && (lat_cnt != 3'd0)) begin
        lat_cnt <= lat_cnt - 3'd1;
      end

      if (read_tc && (t_data_readRegA != data_q)) begin
        mismatch <= 1'b1;
        if (!mismatch) begin
          mismatch_reg <= reg_q;
        end
      end
    end
  end

  always_comb begin
    state_nxt          = state;
    test               = 1'b0;
    busy               = 1'b0;
    done               = 1'b0;
    t_ctrl_writeEnable = 1'b0;
    t_ctrl_writeReg    = 5'd0;
    t_data_writeReg    = 32'd0;
    t_ctrl_readRegA    = 5'd0;

    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_WRITE;
      end
      S_ACCEPT: begin
        test = 1'b1;
        busy = 1'b1;
        if (accept) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        test               = 1'b1;
        busy               = 1'b1;
        t_ctrl_writeEnable = reg_nz;
        t_ctrl_writeReg    = reg_q;
        t_data_writeReg    = data_q;
        if (VERIFY && reg_nz) state_nxt = S_READ;
        else if (last_q)      state_nxt = S_DONE;
        else                  state_nxt = S_ACCEPT;
      end
      S_READ: begin
        test            = 1'b1;
        busy            = 1'b1;
        t_ctrl_readRegA = reg_q;
        if (lat_cnt == 3'd0) state_nxt = last_q ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        test      = 1'b1;
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_test_loader.sv
module tb_regfile_test_loader;
  localparam int RL     = 1;
  localparam bit VERIFY = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_reg = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_last = 1'b0;
  logic        test;
  logic        t_ctrl_writeEnable;
  logic [4:0]  t_ctrl_writeReg;
  logic [31:0] t_data_writeReg;
  logic [4:0]  t_ctrl_readRegA;
  logic [4:0]  t_ctrl_readRegB;
  logic [31:0] t_data_readRegA;
  logic        busy;
  logic        done;
  logic        mismatch;
  logic [4:0]  mismatch_reg;
  logic        err_r0;
  logic [5:0]  write_count;

  always #5 clock = ~clock;

  regfile_test_loader #(.VERIFY(VERIFY), .READ_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg),
    .ld_data(ld_data), .ld_last(ld_last),
    .test(test), .t_ctrl_writeEnable(t_ctrl_writeEnable),
    .t_ctrl_writeReg(t_ctrl_writeReg), .t_data_writeReg(t_data_writeReg),
    .t_ctrl_readRegA(t_ctrl_readRegA), .t_ctrl_readRegB(t_ctrl_readRegB),
    .t_data_readRegA(t_data_readRegA),
    .busy(busy), .done(done), .mismatch(mismatch), .mismatch_reg(mismatch_reg),
    .err_r0(err_r0), .write_count(write_count)
  );

  // Register file stand-in: written only through the test port, with an
  // optional per-register corruption of the port-A readback.
  logic [31:0] rf [32] = '{default: 32'd0};
  logic [31:0] exp_rf [32];
  bit          corrupt_en [32];
  logic [31:0] corrupt_val [32];

  always @(posedge clock)
    if (test && t_ctrl_writeEnable && (t_ctrl_writeReg != 5'd0))
      rf[t_ctrl_writeReg] <= t_data_writeReg;

  always_comb begin
    t_data_readRegA = 32'd0;
    if (t_ctrl_readRegA != 5'd0)
      t_data_readRegA = corrupt_en[t_ctrl_readRegA] ? corrupt_val[t_ctrl_readRegA]
                                                    : rf[t_ctrl_readRegA];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts done pulses, logs handshakes, checks the write cycle
  // that must follow each accepted entry one cycle later.
  int          cyc = 0;
  int          done_cnt = 0;
  int          acc_q[$];
  bit          pend = 1'b0;
  int          pend_cyc = 0;
  logic [4:0]  pend_r;
  logic [31:0] pend_d;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (pend && (cyc == pend_cyc)) begin
      pend = 1'b0;
      chk("write_test_high", test, 1);
      chk("write_enable", t_ctrl_writeEnable, (pend_r != 5'd0));
      if (pend_r != 5'd0) begin
        chk("write_reg", t_ctrl_writeReg, pend_r);
        chk("write_data", t_data_writeReg, pend_d);
      end
    end
    if (reset && ld_valid && ld_ready) begin
      pend     = 1'b1;
      pend_cyc = cyc + 1;
      pend_r   = ld_reg;
      pend_d   = ld_data;
      acc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t sess_q[$];

  int          exp_cnt;
  bit          exp_err;
  bit          exp_mm;
  logic [4:0]  exp_mreg;

  // Session-level reference: counts, sticky flags and final register
  // contents follow directly from the list of entries.
  task automatic model_expect();
    exp_cnt  = 0;
    exp_err  = 1'b0;
    exp_mm   = 1'b0;
    exp_mreg = 5'd0;
    foreach (sess_q[i]) begin
      if (sess_q[i].r == 5'd0) begin
        exp_err = 1'b1;
      end else begin
        if (exp_cnt < 63) exp_cnt++;
        exp_rf[sess_q[i].r] = sess_q[i].d;
        if (VERIFY && corrupt_en[sess_q[i].r] && (corrupt_val[sess_q[i].r] != sess_q[i].d)
            && !exp_mm) begin
          exp_mm   = 1'b1;
          exp_mreg = sess_q[i].r;
        end
      end
    end
  endtask

  task automatic send(input logic [4:0] r, input logic [31:0] d, input logic l);
    int n = 0;
    ld_valid = 1'b1;
    ld_reg   = r;
    ld_data  = d;
    ld_last  = l;
    while (!ld_ready && (n < 100)) begin
      step();
      n++;
    end
    chk("ld_ready_wait", ld_ready, 1);
    step();
  endtask

  task automatic finish_session(input string tag, input int d0);
    int n = 0;
    int bad = 0;
    while (!done && (n < 1000)) begin
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_done_ready"}, ld_ready, 0);
    chk({tag, "_done_test"}, test, 1);
    step();
    chk({tag, "_idle_test"}, test, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_ready"}, ld_ready, 1);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_write_count"}, write_count, exp_cnt);
    chk({tag, "_err_r0"}, err_r0, exp_err);
    chk({tag, "_mismatch"}, mismatch, exp_mm);
    chk({tag, "_mismatch_reg"}, mismatch_reg, exp_mreg);
    chk({tag, "_readRegB"}, t_ctrl_readRegB, 0);
    for (int i = 1; i < 32; i++) if (rf[i] !== exp_rf[i]) bad++;
    chk({tag, "_rf_contents"}, bad, 0);
  endtask

  task automatic run_session(input string tag);
    int d0;
    model_expect();
    d0 = done_cnt;
    foreach (sess_q[i]) send(sess_q[i].r, sess_q[i].d, (i == sess_q.size() - 1));
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    finish_session(tag, d0);
  endtask

  task automatic clear_corrupt();
    for (int i = 0; i < 32; i++) begin
      corrupt_en[i]  = 1'b0;
      corrupt_val[i] = 32'd0;
    end
  endtask

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          cor;
    logic [31:0] cval;
    bit          e_err;
    bit          e_mm;
    logic [4:0]  e_mreg;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    int bad;
    int idx0;
    logic [4:0] r;

    vecs[0] = '{5'd1,  32'd65535,    1'b0, 32'd0,      1'b0, 1'b0, 5'd0, 6'd1};
    vecs[1] = '{5'd0,  32'd5,        1'b0, 32'd0,      1'b1, 1'b0, 5'd0, 6'd0};
    vecs[2] = '{5'd31, 32'hFFFFFFFF, 1'b0, 32'd0,      1'b0, 1'b0, 5'd0, 6'd1};
    vecs[3] = '{5'd7,  32'h1234,     1'b1, 32'hDEAD,   1'b0, 1'b1, 5'd7, 6'd1};
    vecs[4] = '{5'd9,  32'hDEAD,     1'b1, 32'hDEAD,   1'b0, 1'b0, 5'd0, 6'd1};

    for (int i = 0; i < 32; i++) exp_rf[i] = 32'd0;
    clear_corrupt();

    // Reset state
    step(); step(); step();
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_test", test, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", t_ctrl_writeEnable, 0);
    chk("rst_readRegA", t_ctrl_readRegA, 0);
    chk("rst_write_count", write_count, 0);
    chk("rst_flags", {mismatch, err_r0, mismatch_reg}, 0);
    reset = 1'b1;
    step();

    // Single-entry vectors
    foreach (vecs[i]) begin
      clear_corrupt();
      corrupt_en[vecs[i].r]  = vecs[i].cor;
      corrupt_val[vecs[i].r] = vecs[i].cval;
      sess_q.delete();
      sess_q.push_back('{vecs[i].r, vecs[i].d});
      run_session("vec");
      chk("vec_err_r0", err_r0, vecs[i].e_err);
      chk("vec_mismatch", mismatch, vecs[i].e_mm);
      chk("vec_mismatch_reg", mismatch_reg, vecs[i].e_mreg);
      chk("vec_write_count", write_count, vecs[i].e_cnt);
    end
    clear_corrupt();
    chk("vec_r1_value", rf[1], 32'd65535);

    // Burst r1..r31 with valid held; accepts spaced 2+READ_LAT cycles
    sess_q.delete();
    for (int i = 1; i < 32; i++) sess_q.push_back('{5'(i), 32'h1000 + 32'(i)});
    idx0 = acc_q.size();
    run_session("burst");
    chk("burst_accepts", acc_q.size() - idx0, 31);
    bad = 0;
    for (int i = idx0 + 1; i < acc_q.size(); i++)
      if (acc_q[i] - acc_q[i-1] != 2 + RL) bad++;
    chk("burst_spacing", bad, 0);
    chk("burst_r17", rf[17], 32'h1011);

    // r0 entry followed by r2
    sess_q.delete();
    sess_q.push_back('{5'd0, 32'd5});
    sess_q.push_back('{5'd2, 32'd7});
    run_session("r0skip");
    chk("r0skip_r2", rf[2], 32'd7);

    // Corrupted readback on r4 then r5: first mismatch stays r4
    corrupt_en[4] = 1'b1; corrupt_val[4] = 32'hDEAD;
    corrupt_en[5] = 1'b1; corrupt_val[5] = 32'hDEAD;
    sess_q.delete();
    sess_q.push_back('{5'd3, 32'h33});
    sess_q.push_back('{5'd4, 32'h44});
    sess_q.push_back('{5'd5, 32'h55});
    run_session("mism");
    chk("mism_first_reg", mismatch_reg, 5'd4);
    clear_corrupt();

    // Saturating write counter
    sess_q.delete();
    for (int i = 0; i < 70; i++) sess_q.push_back('{5'($urandom_range(1, 31)), $urandom});
    run_session("sat");

    // Reset during READ of the second of three entries
    corrupt_en[10] = 1'b1; corrupt_val[10] = 32'hBAD0;
    d0 = done_cnt;
    send(5'd10, 32'hA0A0, 1'b0);
    send(5'd11, 32'hB1B1, 1'b0);
    ld_reg = 5'd12; ld_data = 32'hC2C2; ld_last = 1'b1;
    step();
    chk("rstmid_in_read", t_ctrl_readRegA, 5'd11);
    chk("rstmid_pre_mismatch", mismatch, 1);
    reset = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    step();
    chk("rstmid_test", test, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", ld_ready, 1);
    chk("rstmid_we", t_ctrl_writeEnable, 0);
    chk("rstmid_readRegA", t_ctrl_readRegA, 0);
    chk("rstmid_write_count", write_count, 0);
    chk("rstmid_flags", {mismatch, err_r0, mismatch_reg}, 0);
    reset = 1'b1;
    step(); step(); step();
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_r10_kept", rf[10], 32'hA0A0);
    chk("rstmid_r12_unwritten", rf[12], exp_rf[12]);
    exp_rf[10] = 32'hA0A0;
    exp_rf[11] = 32'hB1B1;
    clear_corrupt();

    // Stall: valid dropped for 10 cycles while in ACCEPT
    sess_q.delete();
    sess_q.push_back('{5'd20, 32'h2020});
    sess_q.push_back('{5'd21, 32'h2121});
    model_expect();
    d0 = done_cnt;
    send(5'd20, 32'h2020, 1'b0);
    ld_valid = 1'b0;
    n = 0;
    while (!ld_ready && (n < 50)) begin step(); n++; end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(test && busy && ld_ready && !t_ctrl_writeEnable && !done)) bad++;
      step();
    end
    chk("stall_accept_held", bad, 0);
    send(5'd21, 32'h2121, 1'b1);
    ld_valid = 1'b0;
    ld_last = 1'b0;
    finish_session("stall", d0);

    // Randomized sessions against the reference model
    for (int s = 0; s < 12; s++) begin
      clear_corrupt();
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        r = 5'($urandom_range(1, 31));
        corrupt_en[r]  = 1'b1;
        corrupt_val[r] = $urandom;
      end
      sess_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
        r = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        sess_q.push_back('{r, $urandom});
      end
      run_session("rand");
    end
    clear_corrupt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
